// File: rtl/clk_tree_pkg.sv
// -----------------------------------------------------------------------------
// clk_tree_pkg
// Shared definitions for the clock divider tree: default sizes, a constant
// clog2 helper, the per-channel configuration record and the divide-value
// saturation helper (a requested divide of 0 behaves as 1).
// -----------------------------------------------------------------------------
package clk_tree_pkg;

    localparam int DEF_NUM_OUT = 16;
    localparam int DEF_DIV_W   = 8;

    // Divide values travel through the config record at this fixed width so
    // one record type serves every DIV_W below it.
    localparam int MAX_DIV_W   = 32;

    typedef struct packed {
        logic [MAX_DIV_W-1:0] div;
        logic                 en;
    } chan_cfg_t;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >>> 1;
        end
        return res;
    endfunction

    // A divide of 0 would stall the counter; run it as divide-by-1 instead.
    function automatic logic [MAX_DIV_W-1:0] sat_div(input logic [MAX_DIV_W-1:0] div);
        logic [MAX_DIV_W-1:0] res;
        if (div == {MAX_DIV_W{1'b0}}) begin
            res = {{(MAX_DIV_W-1){1'b0}}, 1'b1};
        end else begin
            res = div;
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divided clock channel. Holds an active configuration (divide, enable)
// and a single pending slot. A pending update is applied only at a safe
// point -- channel idle, or the edge where a high phase ends -- so no runt
// pulse or shortened high phase is ever produced. align restarts the phase
// and applies any pending update immediately.
//
// Ports:
//   clk_in    source clock, rising edge
//   reset     synchronous active-high reset
//   cfg_wr    load cfg_data into the pending slot (only issued when pend=0)
//   cfg_data  divide (already saturated to >=1) and enable
//   align     restart the phase on the next edge
//   clk_out   divided clock (register output)
//   running   active enable
//   upd_done  one-cycle pulse after a pending update is applied
//   pend      pending slot occupied
// -----------------------------------------------------------------------------
module clk_div_chan
    import clk_tree_pkg::*;
#(
    parameter int DIV_W    = DEF_DIV_W,
    parameter bit RESET_EN = 1'b0
) (
    input  logic      clk_in,
    input  logic      reset,
    input  logic      cfg_wr,
    input  chan_cfg_t cfg_data,
    input  logic      align,
    output logic      clk_out,
    output logic      running,
    output logic      upd_done,
    output logic      pend
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1'b1);

    logic [DIV_W-1:0] cnt_r,     cnt_s;
    logic             out_r,     out_s;
    logic [DIV_W-1:0] div_act_r, div_act_s;
    logic             en_act_r,  en_act_s;
    logic [DIV_W-1:0] div_p_r,   div_p_s;
    logic             en_p_r,    en_p_s;
    logic             pend_r,    pend_s;
    logic             done_r,    done_s;

    logic             at_term_s;
    logic             apply_s;
    logic [MAX_DIV_W-DIV_W-1:0] cfg_div_unused_s;

    // The top saturates a DIV_W-wide value, so the upper record bits are zero.
    assign cfg_div_unused_s = cfg_data.div[MAX_DIV_W-1:DIV_W];

    assign at_term_s = (cnt_r == (div_act_r - DIV_ONE));
    // Safe point: idle channel, or the edge on which a high phase ends.
    assign apply_s   = pend_r && (align || !en_act_r || (out_r && at_term_s));

    // Next-state for counter, output bit and active configuration.
    always_comb begin
        cnt_s     = cnt_r;
        out_s     = out_r;
        div_act_s = div_act_r;
        en_act_s  = en_act_r;
        if (apply_s) begin
            cnt_s     = {DIV_W{1'b0}};
            out_s     = 1'b0;
            div_act_s = div_p_r;
            en_act_s  = en_p_r;
        end else if (align) begin
            cnt_s = {DIV_W{1'b0}};
            out_s = 1'b0;
        end else if (en_act_r) begin
            if (at_term_s) begin
                cnt_s = {DIV_W{1'b0}};
                out_s = ~out_r;
            end else begin
                cnt_s = cnt_r + DIV_ONE;
                out_s = out_r;
            end
        end else begin
            cnt_s = {DIV_W{1'b0}};
            out_s = 1'b0;
        end
    end

    // Next-state for the pending slot and the update-done pulse.
    always_comb begin
        div_p_s = div_p_r;
        en_p_s  = en_p_r;
        pend_s  = pend_r;
        done_s  = apply_s;
        if (cfg_wr) begin
            div_p_s = cfg_data.div[DIV_W-1:0];
            en_p_s  = cfg_data.en;
            pend_s  = 1'b1;
        end else if (apply_s) begin
            pend_s = 1'b0;
        end else begin
            pend_s = pend_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_r     <= {DIV_W{1'b0}};
            out_r     <= 1'b0;
            div_act_r <= DIV_ONE;
            en_act_r  <= RESET_EN;
            div_p_r   <= DIV_ONE;
            en_p_r    <= 1'b0;
            pend_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            out_r     <= out_s;
            div_act_r <= div_act_s;
            en_act_r  <= en_act_s;
            div_p_r   <= div_p_s;
            en_p_r    <= en_p_s;
            pend_r    <= pend_s;
            done_r    <= done_s;
        end
    end

    assign clk_out  = out_r;
    assign running  = en_act_r;
    assign upd_done = done_r;
    assign pend     = pend_r;

endmodule

// File: rtl/clk_div_tree.sv
// -----------------------------------------------------------------------------
// clk_div_tree
// NUM_OUT independently divided, registered clocks derived from clk_in.
// Configuration arrives one channel at a time over a valid/ready port; each
// channel buffers one update and applies it glitch-free. align re-phases all
// channels together.
//
// Ports:
//   clk_in     source clock, rising edge
//   reset      synchronous active-high reset
//   cfg_valid  config request valid
//   cfg_ready  request accepted this cycle when valid (target slot free)
//   cfg_idx    target channel; indices >= NUM_OUT are accepted and dropped
//   cfg_div    half-period in clk_in cycles (0 runs as 1)
//   cfg_en     channel enable
//   align      one-cycle pulse restarting every channel phase
//   clk_out    divided clocks
//   running    active enable per channel
//   upd_done   one-cycle pulse per channel when its update is applied
// -----------------------------------------------------------------------------
module clk_div_tree
    import clk_tree_pkg::*;
#(
    parameter int NUM_OUT  = DEF_NUM_OUT,
    parameter int DIV_W    = DEF_DIV_W,
    parameter bit RESET_EN = 1'b0,
    localparam int IDX_W   = (NUM_OUT > 1) ? clog2(NUM_OUT) : 1
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic               cfg_en,
    input  logic               align,
    output logic [NUM_OUT-1:0] clk_out,
    output logic [NUM_OUT-1:0] running,
    output logic [NUM_OUT-1:0] upd_done
);

    logic [NUM_OUT-1:0] pend_s;
    logic [NUM_OUT-1:0] cfg_wr_s;
    logic               idx_ok_s;
    logic               pend_sel_s;
    logic               cfg_ready_s;
    chan_cfg_t          cfg_data_s;

    assign idx_ok_s = (int'(cfg_idx) < NUM_OUT);

    // Pending flag of the addressed channel; out-of-range targets never stall.
    always_comb begin
        pend_sel_s = 1'b0;
        if (idx_ok_s) begin
            pend_sel_s = pend_s[cfg_idx];
        end else begin
            pend_sel_s = 1'b0;
        end
    end

    assign cfg_ready_s = !reset && !align && !pend_sel_s;
    assign cfg_ready   = cfg_ready_s;

    assign cfg_data_s.div = sat_div(MAX_DIV_W'(cfg_div));
    assign cfg_data_s.en  = cfg_en;

    // One channel per output; the write strobe is the decoded transfer.
    for (genvar ch = 0; ch < NUM_OUT; ch++) begin : g_chan
        assign cfg_wr_s[ch] = cfg_valid && cfg_ready_s && (cfg_idx == IDX_W'(ch));

        clk_div_chan #(
            .DIV_W    (DIV_W),
            .RESET_EN (RESET_EN)
        ) u_chan (
            .clk_in   (clk_in),
            .reset    (reset),
            .cfg_wr   (cfg_wr_s[ch]),
            .cfg_data (cfg_data_s),
            .align    (align),
            .clk_out  (clk_out[ch]),
            .running  (running[ch]),
            .upd_done (upd_done[ch]),
            .pend     (pend_s[ch])
        );
    end

endmodule
